// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Handshake bundle between a decode stage, the ALU issue controller and the ALU.
//
// Signals:
//   in_valid   requester -> ctrl  decode request present
//   in_ready   ctrl -> requester  controller accepts the request this cycle
//   instr      requester -> ctrl  instruction word (only [5:0] is used)
//   alu_op     requester -> ctrl  main-decoder ALU operation class
//   out_valid  ctrl -> ALU        registered function code valid
//   out_ready  ALU -> ctrl        ALU accepts the function code
//   alu_fn     ctrl -> ALU        function code, zero-extended from 6 bits
//   alu_mc     ctrl -> ALU        alu_fn is a multi-cycle function
//   illegal    ctrl -> ALU        alu_op 3'b111 decoded (only with out_valid)
//   busy       ctrl -> all        multi-cycle interval in progress
//
// Modports:
//   master  the environment (requester + ALU) around the controller
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
  parameter int FN_W = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      alu_op;
  logic            out_valid;
  logic            out_ready;
  logic [FN_W-1:0] alu_fn;
  logic            alu_mc;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, instr, alu_op, out_ready,
    input  in_ready, out_valid, alu_fn, alu_mc, illegal, busy
  );

  modport slave (
    input  in_valid, instr, alu_op, out_ready,
    output in_ready, out_valid, alu_fn, alu_mc, illegal, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Decodes the ALU function code from the main-decoder operation class and the
// instruction funct field, holds it in a one-entry output register with a
// valid/ready handshake, and stalls new requests for MC_LAT cycles after a
// multi-cycle function has been handed to the ALU.
//
// Parameters:
//   FN_W      ALU function code width (>= 6)
//   MC_LAT    busy cycles after a multi-cycle function issues (1..255)
//   MC_CNT_W  busy counter width, 2**MC_CNT_W > MC_LAT
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_issue_ctrl_if.slave handshake bundle (see interface file)
//
// Configuration macro:
//   ALU_ISSUE_ILLEGAL_TRAP_EN  when defined, alu_op 3'b111 raises illegal=1;
//                              when undefined, illegal is tied 0 and 3'b111
//                              issues as a plain function 0x00.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int FN_W     = 6,
  parameter int MC_LAT   = 4,
  parameter int MC_CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FULL = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          fn_q, fn_d;
  logic                mc_q, mc_d;
  logic                ill_q, ill_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] dec_fn;
  logic       dec_mc;
  logic       dec_ill;
  logic       in_ready;
  logic       accept;

  // Upper instruction bits are not part of the function decode.
  logic unused_instr;
  assign unused_instr = ^bus.instr[31:6];

  // Function decode of the incoming request.
  always_comb begin
    dec_fn  = 6'h00;
    dec_mc  = 1'b0;
    dec_ill = 1'b0;
    unique case (bus.alu_op)
      3'b000: dec_fn = 6'h00;
      3'b001: dec_fn = 6'h01;
      3'b010: begin
        dec_fn = bus.instr[5:0];
        // 0x18..0x1B share the upper funct bits 4'b0110.
        dec_mc = (bus.instr[5:2] == 4'b0110);
      end
      3'b011: dec_fn = 6'h00;
      3'b100: dec_fn = 6'h04;
      3'b101: dec_fn = 6'h06;
      3'b110: dec_fn = 6'h0B;
      3'b111: begin
        dec_fn = 6'h00;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        dec_ill = 1'b1;
`else
        dec_ill = 1'b0;
`endif
      end
      default: dec_fn = 6'h00;
    endcase
  end

  // A held multi-cycle code blocks the bypass accept: its handshake cycle
  // starts the busy interval instead.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      FULL:    in_ready = bus.out_ready && !mc_q;
      BUSY:    in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    fn_d        = fn_q;
    mc_d        = mc_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = FULL;
          fn_d        = dec_fn;
          mc_d        = dec_mc;
          ill_d       = dec_ill;
          out_valid_d = 1'b1;
        end
      end
      FULL: begin
        if (bus.out_ready && mc_q) begin
          state_d     = BUSY;
          out_valid_d = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = MC_CNT_W'(MC_LAT);
        end else if (accept) begin
          fn_d  = dec_fn;
          mc_d  = dec_mc;
          ill_d = dec_ill;
        end else if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - MC_CNT_W'(1);
        if (cnt_q == MC_CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops any held code and busy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fn_q        <= 6'h00;
      mc_q        <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      fn_q        <= fn_d;
      mc_q        <= mc_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_fn    = FN_W'(fn_q);
  assign bus.alu_mc    = mc_q;
  assign bus.illegal   = ill_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL provide parameter FN_W, default 6, ALU function code width; values below 6 are unsupported.
REQ-002 SHALL provide parameter MC_LAT, default 4, number of busy cycles after a multi-cycle function issues; legal range 1..255.
REQ-003 SHALL provide parameter MC_CNT_W, default 8, width of the busy counter; SHALL satisfy 2^MC_CNT_W > MC_LAT.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  decode request present.
REQ-008 in_ready  output  1  block accepts request this cycle.
REQ-009 instr  input  32  instruction word; only instr[5:0] is used.
REQ-010 alu_op  input  3  main-decoder ALU operation class.
REQ-011 out_valid  output  1  registered function code valid.
REQ-012 out_ready  input  1  ALU accepts function code.
REQ-013 alu_fn  output  FN_W  function code, zero-extended from 6 bits.
REQ-014 alu_mc  output  1  alu_fn is a multi-cycle function.
REQ-015 illegal  output  1  alu_op 3'b111 decoded; valid only with out_valid.
REQ-016 busy  output  1  multi-cycle interval in progress.

Function
REQ-017 Decode SHALL be: 010 -> instr[5:0]; 000 -> 0x00; 001 -> 0x01; 011 -> 0x00; 100 -> 0x04; 101 -> 0x06; 110 -> 0x0B; 111 -> 0x00.
REQ-018 alu_mc SHALL be 1 iff alu_op==010 and instr[5:0] is in 0x18..0x1B.
REQ-019 States: IDLE (no output), FULL (out_valid=1), BUSY (counter running); out_valid=1 only in FULL.
REQ-020 in_ready SHALL be 1 in IDLE; in FULL only when out_ready=1 and the held alu_mc=0; 0 in BUSY.
REQ-021 Accept (in_valid and in_ready) SHALL register alu_fn, alu_mc and illegal and set out_valid on the next edge (latency 1 cycle).
REQ-022 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 FULL with out_ready=1 and alu_mc=0 SHALL go to FULL on a simultaneous accept, otherwise to IDLE (back-to-back throughput 1 per cycle).
REQ-024 FULL with out_ready=1 and alu_mc=1 SHALL load the counter with MC_LAT and go to BUSY; no accept occurs that cycle.
REQ-025 BUSY SHALL decrement the counter each cycle and go to IDLE on the cycle it reads 1; busy=1 for exactly MC_LAT cycles.
REQ-026 in_valid in BUSY SHALL be ignored with no state change; the requester holds it.
REQ-027 Nothing in the block SHALL infer a latch.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, counter=0, out_valid=0, alu_fn=0, alu_mc=0, illegal=0, busy=0; in_ready=1 from the first edge after release.
REQ-029 Reset during FULL or BUSY SHALL discard the held code and the remaining busy count.

Configuration
REQ-030 Macro ALU_ISSUE_ILLEGAL_TRAP_EN defined: alu_op 111 registers illegal=1 with alu_fn=0x00.
REQ-031 Macro undefined: illegal SHALL be tied 0, and alu_op 111 issues as a plain 0x00.

Verification
REQ-032 Reset, then alu_op=100 with in_valid=1 and out_ready=1 -> one cycle later out_valid=1, alu_fn=0x04, alu_mc=0.
REQ-033 alu_op=010, instr[5:0]=0x22 streamed for 3 cycles with out_ready=1 -> three consecutive out_valid cycles of 0x22, in_ready held 1.
REQ-034 alu_op=110 with out_ready=0 for 5 cycles -> alu_fn=0x0B stable, in_ready=0; out_ready=1 -> IDLE or next accept.
REQ-035 alu_op=010, instr[5:0]=0x18, MC_LAT=4 -> after output handshake busy=1 and in_ready=0 for exactly 4 cycles; a request held meanwhile is accepted in the cycle after busy falls.
REQ-036 alu_op=111 -> with macro defined illegal=1 and alu_fn=0; without it, illegal=0.
REQ-037 rst_n low mid-BUSY (2 cycles left) -> all outputs 0 immediately, in_ready=1 after release, no residual busy.
